// File: rtl/scan_response_serializer.sv
`default_nettype none
// ============================================================================
// Module      : scan_response_serializer
// Description : Parallel-to-serial transmitter for captured test responses,
//               one WIDTH-bit word per frame, optional trailing even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_response_serializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_valid,
    output logic             cap_ready,
    input  logic [WIDTH-1:0] cap_data,
    output logic             so_valid,
    input  logic             so_ready,
    output logic             so_data,
    output logic             so_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;

    localparam logic [CW-1:0] c_cnt_last   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_penult = CW'(WIDTH - 2);
    localparam logic          c_parity_en  = (PARITY_EN != 0);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic             r_cap_ready;
    logic             r_so_valid;
    logic             r_so_data;
    logic             r_so_last;

    logic [WIDTH-1:0] w_shreg_shift;
    logic             w_cap_first;
    logic             w_next_bit;

    // Rotate rather than zero-fill: the wrapped bits are never presented,
    // and every register bit stays observable.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_shreg_shift = {r_shreg[0], r_shreg[WIDTH-1:1]};
            assign w_cap_first   = cap_data[0];
            assign w_next_bit    = r_shreg[1];
        end else begin : g_msb_first
            assign w_shreg_shift = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
            assign w_cap_first   = cap_data[WIDTH-1];
            assign w_next_bit    = r_shreg[WIDTH-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_cap_ready <= 1'b1;
            r_so_valid  <= 1'b0;
            r_so_data   <= 1'b0;
            r_so_last   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cap_valid) begin
                        r_state     <= c_st_shift;
                        r_shreg     <= cap_data;
                        r_cnt       <= '0;
                        r_par       <= ^cap_data;
                        r_cap_ready <= 1'b0;
                        r_so_valid  <= 1'b1;
                        r_so_data   <= w_cap_first;
                        r_so_last   <= 1'b0;
                    end
                end
                c_st_shift: begin
                    if (so_ready) begin
                        r_shreg <= w_shreg_shift;
                        if (r_cnt == c_cnt_last) begin
                            if (c_parity_en) begin
                                r_state   <= c_st_parity;
                                r_so_data <= r_par;
                                r_so_last <= 1'b1;
                            end else begin
                                r_state     <= c_st_idle;
                                r_cap_ready <= 1'b1;
                                r_so_valid  <= 1'b0;
                                r_so_data   <= 1'b0;
                                r_so_last   <= 1'b0;
                            end
                        end else begin
                            // Counter holds at the last index instead of wrapping.
                            r_cnt     <= r_cnt + 1'b1;
                            r_so_data <= w_next_bit;
                            r_so_last <= !c_parity_en && (r_cnt == c_cnt_penult);
                        end
                    end
                end
                c_st_parity: begin
                    if (so_ready) begin
                        r_state     <= c_st_idle;
                        r_cap_ready <= 1'b1;
                        r_so_valid  <= 1'b0;
                        r_so_data   <= 1'b0;
                        r_so_last   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_cap_ready <= 1'b1;
                    r_so_valid  <= 1'b0;
                    r_so_data   <= 1'b0;
                    r_so_last   <= 1'b0;
                end
            endcase
        end
    end

    assign cap_ready = r_cap_ready;
    assign so_valid  = r_so_valid;
    assign so_data   = r_so_data;
    assign so_last   = r_so_last;

endmodule
`default_nettype wire

// File: tb/tb_scan_response_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_response_serializer
// Description : Directed self-checking bench for scan_response_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_response_serializer;

    logic clk;
    logic rst_n;

    // u0: WIDTH=8, LSB first, no parity
    logic       cap_valid0, cap_ready0, so_valid0, so_ready0, so_data0, so_last0;
    logic [7:0] cap_data0;
    // u1: WIDTH=8, LSB first, parity
    logic       cap_valid1, cap_ready1, so_valid1, so_ready1, so_data1, so_last1;
    logic [7:0] cap_data1;
    // u2: WIDTH=8, MSB first, no parity
    logic       cap_valid2, cap_ready2, so_valid2, so_ready2, so_data2, so_last2;
    logic [7:0] cap_data2;

    int n_tests;
    int n_fail;

    scan_response_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cap_valid(cap_valid0), .cap_ready(cap_ready0), .cap_data(cap_data0),
        .so_valid(so_valid0), .so_ready(so_ready0), .so_data(so_data0), .so_last(so_last0)
    );

    scan_response_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cap_valid(cap_valid1), .cap_ready(cap_ready1), .cap_data(cap_data1),
        .so_valid(so_valid1), .so_ready(so_ready1), .so_data(so_data1), .so_last(so_last1)
    );

    scan_response_serializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .cap_valid(cap_valid2), .cap_ready(cap_ready2), .cap_data(cap_data2),
        .so_valid(so_valid2), .so_ready(so_ready2), .so_data(so_data2), .so_last(so_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One u0 frame starting at a negedge. seq bit i is the expected beat i.
    // so_ready is low on post-accept cycles slo..shi; pend/pend_data drive
    // cap_valid/cap_data while the frame is shifting.
    task automatic frame0(input string tag, input logic [7:0] data, input logic [7:0] seq,
                          input int slo, input int shi,
                          input logic pend, input logic [7:0] pend_data);
        int beats;
        int cyc;
        cap_valid0 = 1'b1;
        cap_data0  = data;
        so_ready0  = 1'b1;
        check({tag, " cap_ready@accept"}, cap_ready0, 1);
        @(negedge clk);
        cap_valid0 = pend;
        cap_data0  = pend_data;
        beats = 0;
        cyc   = 1;
        while (beats < 8 && cyc < 40) begin
            so_ready0 = !(cyc >= slo && cyc <= shi);
            check({tag, " so_valid"}, so_valid0, 1);
            check({tag, " so_data"}, so_data0, seq[beats]);
            check({tag, " so_last"}, so_last0, (beats == 7) ? 1 : 0);
            check({tag, " cap_ready busy"}, cap_ready0, 0);
            if (so_ready0) beats++;
            @(negedge clk);
            cyc++;
        end
        so_ready0 = 1'b1;
        check({tag, " beat count"}, beats, 8);
        check({tag, " cycles"}, cyc, 9 + ((shi >= slo) ? (shi - slo + 1) : 0));
        check({tag, " so_valid bubble"}, so_valid0, 0);
        check({tag, " cap_ready bubble"}, cap_ready0, 1);
    endtask

    initial begin
        logic [8:0] seq9;
        logic [7:0] seq8;
        int         beats;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        cap_valid0 = 0; cap_data0 = '0; so_ready0 = 1;
        cap_valid1 = 0; cap_data1 = '0; so_ready1 = 1;
        cap_valid2 = 0; cap_data2 = '0; so_ready2 = 1;

        // Reset state
        @(negedge clk);
        check("rst cap_ready", cap_ready0, 1);
        check("rst so_valid", so_valid0, 0);
        check("rst so_data", so_data0, 0);
        check("rst so_last", so_last0, 0);
        check("rst u1 cap_ready", cap_ready1, 1);
        check("rst u2 so_valid", so_valid2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: A5 LSB first -> 1,0,1,0,0,1,0,1
        frame0("t1", 8'hA5, 8'hA5, 100, 0, 1'b0, 8'h00);

        // Test 3: stall on cycles 3-5 of an A5 frame
        frame0("t3", 8'hA5, 8'hA5, 3, 5, 1'b0, 8'h00);

        // Test 4: FF presented during the 3C frame, accepted in the bubble
        frame0("t4a", 8'h3C, 8'h3C, 100, 0, 1'b1, 8'hFF);
        check("t4 cap_valid pending", cap_valid0, 1);
        frame0("t4b", 8'hFF, 8'hFF, 100, 0, 1'b0, 8'h00);

        // Test 5: reset after 4 beats of A5
        cap_valid0 = 1'b1;
        cap_data0  = 8'hA5;
        @(negedge clk);
        cap_valid0 = 1'b0;
        repeat (4) @(negedge clk);
        check("t5 so_valid before rst", so_valid0, 1);
        check("t5 so_data beat4", so_data0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5 so_valid async rst", so_valid0, 0);
        check("t5 cap_ready async rst", cap_ready0, 1);
        check("t5 so_data async rst", so_data0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame0("t5", 8'h3C, 8'h3C, 100, 0, 1'b0, 8'h00);

        // Test 2: parity, 07 -> 1,1,1,0,0,0,0,0 then parity 1
        seq9 = 9'b1_0000_0111;
        cap_valid1 = 1'b1;
        cap_data1  = 8'h07;
        check("t2 cap_ready", cap_ready1, 1);
        @(negedge clk);
        cap_valid1 = 1'b0;
        beats = 0;
        while (beats < 9 && so_valid1 === 1'b1) begin
            check("t2 so_data", so_data1, seq9[beats]);
            check("t2 so_last", so_last1, (beats == 8) ? 1 : 0);
            beats++;
            @(negedge clk);
        end
        check("t2 beat count", beats, 9);
        check("t2 cap_ready after", cap_ready1, 1);

        // Test 6: MSB first, 80 -> 1 then seven 0
        seq8 = 8'b0000_0001;
        cap_valid2 = 1'b1;
        cap_data2  = 8'h80;
        @(negedge clk);
        cap_valid2 = 1'b0;
        beats = 0;
        while (beats < 8 && so_valid2 === 1'b1) begin
            check("t6 so_data", so_data2, seq8[beats]);
            check("t6 so_last", so_last2, (beats == 7) ? 1 : 0);
            beats++;
            @(negedge clk);
        end
        check("t6 beat count", beats, 8);
        check("t6 cap_ready after", cap_ready2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
